// File: rtl/pulse_former_hs_pkg.sv
//------------------------------------------------------------------------------
// pulse_former_hs_pkg : state encodings and parameter defaults
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

package pulse_former_hs_pkg;

   localparam int PF_W_DEFAULT    = 8;
   localparam int PF_GAP_DEFAULT  = 5;
   localparam int PF_LEN0_DEFAULT = 6;

   typedef enum logic [0:0] {
      ST_GAP  = 1'b0,
      ST_HIGH = 1'b1
   } pulse_state_e;

   typedef enum logic [1:0] {
      HS_IDLE = 2'd0,
      HS_REQ  = 2'd1,
      HS_WAIT = 2'd2
   } hs_state_e;

endpackage

`default_nettype wire

// File: rtl/pulse_former_hs_if.sv
//------------------------------------------------------------------------------
// pulse_former_hs_if : converter handshake and pulse output bundle
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface pulse_former_hs_if
   import pulse_former_hs_pkg::*;
#(
   parameter int W = PF_W_DEFAULT
);
   logic         soc;
   logic         eoc;
   logic [W-1:0] numero;
   logic         out;
   logic         late;
   logic [W-1:0] len_q;

   modport master (
      output soc,
      input  eoc,
      input  numero,
      output out,
      output late,
      output len_q
   );

   modport slave (
      input  soc,
      output eoc,
      output numero,
      input  out,
      input  late,
      input  len_q
   );
endinterface

`default_nettype wire

// File: rtl/pulse_former_hs_hs_master.sv
//------------------------------------------------------------------------------
// hs_master : soc/eoc request handshake toward the converter
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module hs_master
   import pulse_former_hs_pkg::*;
(
   input  wire logic clk,
   input  wire logic rst,
   input  wire logic start_i,
   input  wire logic eoc_i,
   output logic      soc_o,
   output logic      busy_o,
   output logic      capture_o
);

   hs_state_e state_q;
   logic      soc_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= HS_IDLE;
         soc_q   <= 1'b0;
      end else begin
         case (state_q)
            HS_IDLE: begin
               if (start_i) begin
                  soc_q   <= 1'b1;
                  state_q <= HS_REQ;
               end
            end
            // The converter acknowledges by going busy; a stuck-high eoc
            // keeps the request open indefinitely.
            HS_REQ: begin
               if (!eoc_i) begin
                  soc_q   <= 1'b0;
                  state_q <= HS_WAIT;
               end
            end
            HS_WAIT: begin
               if (eoc_i) begin
                  state_q <= HS_IDLE;
               end
            end
            default: begin
               soc_q   <= 1'b0;
               state_q <= HS_IDLE;
            end
         endcase
      end
   end

   assign soc_o     = soc_q;
   assign busy_o    = (state_q != HS_IDLE);
   assign capture_o = (state_q == HS_WAIT) && eoc_i;

endmodule

`default_nettype wire

// File: rtl/pulse_former_hs.sv
//------------------------------------------------------------------------------
// pulse_former_hs : gap/high pulse generator whose length is refreshed by a
//                   converter handshake launched at each pulse start
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module pulse_former_hs
   import pulse_former_hs_pkg::*;
#(
   parameter int W    = PF_W_DEFAULT,
   parameter int GAP  = PF_GAP_DEFAULT,
   parameter int LEN0 = PF_LEN0_DEFAULT
)(
   input  wire logic         clk,
   input  wire logic         rst,
   pulse_former_hs_if.master bus
);

   localparam logic [W-1:0] GAP_CNT  = W'(GAP);
   localparam logic [W-1:0] LEN0_CNT = W'(LEN0);
   localparam logic [W-1:0] CNT_ONE  = {{(W-1){1'b0}}, 1'b1};

   pulse_state_e state_q;
   logic [W-1:0] cnt_q;
   logic [W-1:0] len_q;
   logic [W-1:0] len_d;
   logic         out_q;
   logic         late_q;
   logic         hs_start;
   logic         hs_busy;
   logic         hs_capture;
   logic         hs_soc;

   assign hs_start = (state_q == ST_GAP) && (cnt_q == CNT_ONE);

   // A zero-length request is promoted to one cycle so the pulse never vanishes.
   assign len_d = hs_capture ? ((bus.numero == '0) ? CNT_ONE : bus.numero) : len_q;

   hs_master u_hs_master (
      .clk       (clk),
      .rst       (rst),
      .start_i   (hs_start),
      .eoc_i     (bus.eoc),
      .soc_o     (hs_soc),
      .busy_o    (hs_busy),
      .capture_o (hs_capture)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_GAP;
         cnt_q   <= GAP_CNT;
         out_q   <= 1'b0;
         late_q  <= 1'b0;
         len_q   <= LEN0_CNT;
      end else begin
         len_q  <= len_d;
         late_q <= 1'b0;
         case (state_q)
            // Old len_q is loaded here, so a capture on this same edge only
            // affects the following pulse.
            ST_GAP: begin
               if (cnt_q == CNT_ONE) begin
                  state_q <= ST_HIGH;
                  cnt_q   <= len_q;
                  out_q   <= 1'b1;
                  late_q  <= hs_busy;
               end else begin
                  cnt_q <= cnt_q - CNT_ONE;
               end
            end
            ST_HIGH: begin
               if (cnt_q == CNT_ONE) begin
                  state_q <= ST_GAP;
                  cnt_q   <= GAP_CNT;
                  out_q   <= 1'b0;
               end else begin
                  cnt_q <= cnt_q - CNT_ONE;
               end
            end
            default: begin
               state_q <= ST_GAP;
               cnt_q   <= GAP_CNT;
               out_q   <= 1'b0;
            end
         endcase
      end
   end

   assign bus.out   = out_q;
   assign bus.late  = late_q;
   assign bus.len_q = len_q;
   assign bus.soc   = hs_soc;

endmodule

`default_nettype wire

// File: tb/tb_pulse_former_hs.sv
//------------------------------------------------------------------------------
// tb_pulse_former_hs : scenario tasks plus randomized converter against a
//                      timeline reference model
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_pulse_former_hs;

   localparam int GAP  = 5;
   localparam int LEN0 = 6;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks   = 0;
   int   failures = 0;

   pulse_former_hs_if #(.W(8)) bus8 ();
   pulse_former_hs_if #(.W(4)) bus4 ();

   pulse_former_hs #(.W(8), .GAP(GAP), .LEN0(LEN0)) dut8 (.clk(clk), .rst(rst), .bus(bus8));
   pulse_former_hs #(.W(4), .GAP(GAP), .LEN0(LEN0)) dut4 (.clk(clk), .rst(rst), .bus(bus4));

   always #5 clk = ~clk;

   // Timeline model: absolute cycle numbers of the next rise and fall, plus
   // whether a request is outstanding or a result is awaited.
   typedef struct {
      int nxt;
      int rise;
      int fall;
      int len;
      bit req;
      bit wt;
      bit out;
      bit soc;
      bit late;
   } model_t;

   model_t m8, m4;

   function automatic model_t model_step(model_t s, logic r, logic e, int num);
      model_t n;
      bit     open_hs;
      bit     cap;
      n = s;
      if (r === 1'b1) begin
         n.nxt = 1; n.rise = GAP; n.fall = -1; n.len = LEN0;
         n.req = 0; n.wt = 0; n.out = 0; n.soc = 0; n.late = 0;
         return n;
      end
      open_hs = s.req || s.wt;
      cap     = s.wt && (e === 1'b1);
      if (s.req && (e === 1'b0)) begin
         n.req = 0; n.wt = 1; n.soc = 0;
      end
      if (cap) n.wt = 0;
      n.late = 0;
      if (s.nxt == s.rise) begin
         n.out  = 1;
         n.fall = s.rise + s.len;
         n.late = open_hs;
         if (!open_hs) begin
            n.req = 1; n.soc = 1;
         end
      end else if (s.nxt == s.fall) begin
         n.out  = 0;
         n.rise = s.fall + GAP;
      end
      if (cap) n.len = (num == 0) ? 1 : num;
      n.nxt = s.nxt + 1;
      return n;
   endfunction

   always @(posedge clk) begin
      m8 = model_step(m8, rst, bus8.eoc, int'(bus8.numero));
      m4 = model_step(m4, rst, bus4.eoc, int'(bus4.numero));
   end

   // Converter behind dut8: waits conv_lat cycles after seeing soc, stays busy
   // for conv_busy cycles, then presents conv_num with eoc high.
   int conv_lat  = 0;
   int conv_busy = 2;
   int conv_num  = 3;
   bit conv_rand = 0;
   int cv_state  = 0;
   int cv_cnt    = 0;

   initial begin
      bus8.eoc = 1'b1; bus8.numero = '0;
      bus4.eoc = 1'b1; bus4.numero = '0;
      forever begin
         @(negedge clk);
         if (rst) begin
            bus8.eoc = 1'b1; cv_state = 0;
         end else begin
            case (cv_state)
               0: if (bus8.soc) begin
                     if (conv_rand) begin
                        conv_lat  = $urandom_range(0, 4);
                        conv_busy = $urandom_range(1, 25);
                        conv_num  = $urandom_range(0, 20);
                     end
                     cv_cnt = conv_lat; cv_state = 1;
                     if (cv_cnt == 0) begin
                        bus8.eoc = 1'b0; cv_cnt = conv_busy; cv_state = 2;
                     end
                  end
               1: begin
                     cv_cnt--;
                     if (cv_cnt <= 0) begin
                        bus8.eoc = 1'b0; cv_cnt = conv_busy; cv_state = 2;
                     end
                  end
               default: begin
                     cv_cnt--;
                     if (cv_cnt <= 0) begin
                        bus8.eoc = 1'b1; bus8.numero = 8'(conv_num); cv_state = 0;
                     end
                  end
            endcase
         end
      end
   end

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_reset();
      repeat (3) @(negedge clk);
      checks += 4;
      if (bus8.out !== 1'b0) begin failures++; $display("FAIL reset_out8 got=%b exp=0", bus8.out); end
      if (bus8.soc !== 1'b0) begin failures++; $display("FAIL reset_soc8 got=%b exp=0", bus8.soc); end
      if (bus8.late !== 1'b0) begin failures++; $display("FAIL reset_late8 got=%b exp=0", bus8.late); end
      if (bus8.len_q !== 8'd6) begin failures++; $display("FAIL reset_len8 got=%0d exp=6", bus8.len_q); end
      checks += 2;
      if (bus4.out !== 1'b0) begin failures++; $display("FAIL reset_out4 got=%b exp=0", bus4.out); end
      if (bus4.len_q !== 4'd6) begin failures++; $display("FAIL reset_len4 got=%0d exp=6", bus4.len_q); end
   endtask

   task automatic test_prompt();
      bit e;
      conv_lat = 0; conv_busy = 2; conv_num = 3;
      do_reset();
      for (int i = 0; i < 31; i++) begin
         checks++;
         if ({bus8.out, bus8.soc, bus8.late} !== {m8.out, m8.soc, m8.late} || bus8.len_q !== 8'(m8.len)) begin
            failures++;
            $display("FAIL prompt_model cyc=%0d out/soc/late/len got=%b%b%b/%0d exp=%b%b%b/%0d",
                     i, bus8.out, bus8.soc, bus8.late, bus8.len_q, m8.out, m8.soc, m8.late, m8.len);
         end
         if (i <= 23) begin
            e = (i >= 5 && i <= 10) || (i >= 16 && i <= 18);
            checks++;
            if (bus8.out !== e) begin failures++; $display("FAIL prompt_out cyc=%0d got=%b exp=%b", i, bus8.out, e); end
         end
         if (i == 20) begin
            checks++;
            if (bus8.len_q !== 8'd3) begin failures++; $display("FAIL prompt_len got=%0d exp=3", bus8.len_q); end
         end
         @(negedge clk);
      end
   endtask

   task automatic test_zero_numero();
      conv_lat = 0; conv_busy = 2; conv_num = 0;
      do_reset();
      for (int i = 0; i < 30; i++) begin
         checks++;
         if ({bus8.out, bus8.soc, bus8.late} !== {m8.out, m8.soc, m8.late} || bus8.len_q !== 8'(m8.len)) begin
            failures++;
            $display("FAIL zero_model cyc=%0d out/soc/late/len got=%b%b%b/%0d exp=%b%b%b/%0d",
                     i, bus8.out, bus8.soc, bus8.late, bus8.len_q, m8.out, m8.soc, m8.late, m8.len);
         end
         if (i == 12 || i == 16 || i == 17 || i == 22 || i == 23) begin
            checks++;
            if (bus8.out !== (i == 16 || i == 22)) begin
               failures++; $display("FAIL zero_out cyc=%0d got=%b exp=%b", i, bus8.out, (i == 16 || i == 22));
            end
         end
         if (i == 12) begin
            checks++;
            if (bus8.len_q !== 8'd1) begin failures++; $display("FAIL zero_len got=%0d exp=1", bus8.len_q); end
         end
         @(negedge clk);
      end
   endtask

   task automatic test_busy_late();
      conv_lat = 0; conv_busy = 20; conv_num = 4;
      do_reset();
      for (int i = 0; i < 40; i++) begin
         checks++;
         if ({bus8.out, bus8.soc, bus8.late} !== {m8.out, m8.soc, m8.late} || bus8.len_q !== 8'(m8.len)) begin
            failures++;
            $display("FAIL busy_model cyc=%0d out/soc/late/len got=%b%b%b/%0d exp=%b%b%b/%0d",
                     i, bus8.out, bus8.soc, bus8.late, bus8.len_q, m8.out, m8.soc, m8.late, m8.len);
         end
         if (i == 16) begin
            checks += 3;
            if (bus8.late !== 1'b1) begin failures++; $display("FAIL busy_late16 got=%b exp=1", bus8.late); end
            if (bus8.soc !== 1'b0) begin failures++; $display("FAIL busy_soc16 got=%b exp=0", bus8.soc); end
            if (bus8.len_q !== 8'd6) begin failures++; $display("FAIL busy_len16 got=%0d exp=6", bus8.len_q); end
         end
         if (i == 17) begin
            checks++;
            if (bus8.late !== 1'b0) begin failures++; $display("FAIL busy_late17 got=%b exp=0", bus8.late); end
         end
         if (i == 21 || i == 22) begin
            checks++;
            if (bus8.out !== (i == 21)) begin failures++; $display("FAIL busy_out cyc=%0d got=%b exp=%b", i, bus8.out, (i == 21)); end
         end
         @(negedge clk);
      end
   endtask

   task automatic test_same_edge();
      conv_lat = 0; conv_busy = 10; conv_num = 9;
      do_reset();
      for (int i = 0; i < 40; i++) begin
         checks++;
         if ({bus8.out, bus8.soc, bus8.late} !== {m8.out, m8.soc, m8.late} || bus8.len_q !== 8'(m8.len)) begin
            failures++;
            $display("FAIL edge_model cyc=%0d out/soc/late/len got=%b%b%b/%0d exp=%b%b%b/%0d",
                     i, bus8.out, bus8.soc, bus8.late, bus8.len_q, m8.out, m8.soc, m8.late, m8.len);
         end
         if (i == 16) begin
            checks += 2;
            if (bus8.late !== 1'b1) begin failures++; $display("FAIL edge_late got=%b exp=1", bus8.late); end
            if (bus8.len_q !== 8'd9) begin failures++; $display("FAIL edge_len got=%0d exp=9", bus8.len_q); end
         end
         if (i == 21 || i == 22 || i == 35 || i == 36) begin
            checks++;
            if (bus8.out !== (i == 21 || i == 35)) begin
               failures++; $display("FAIL edge_out cyc=%0d got=%b exp=%b", i, bus8.out, (i == 21 || i == 35));
            end
         end
         @(negedge clk);
      end
   endtask

   task automatic test_reset_mid();
      conv_lat = 0; conv_busy = 2; conv_num = 3;
      do_reset();
      for (int i = 0; i < 34; i++) begin
         checks++;
         if ({bus8.out, bus8.soc, bus8.late} !== {m8.out, m8.soc, m8.late} || bus8.len_q !== 8'(m8.len)) begin
            failures++;
            $display("FAIL rmid_model cyc=%0d out/soc/late/len got=%b%b%b/%0d exp=%b%b%b/%0d",
                     i, bus8.out, bus8.soc, bus8.late, bus8.len_q, m8.out, m8.soc, m8.late, m8.len);
         end
         if (i == 15) conv_lat = 10;
         if (i == 18) begin
            checks += 2;
            if (bus8.soc !== 1'b1) begin failures++; $display("FAIL rmid_soc18 got=%b exp=1", bus8.soc); end
            if (bus8.len_q !== 8'd3) begin failures++; $display("FAIL rmid_len18 got=%0d exp=3", bus8.len_q); end
            rst = 1'b1;
         end
         if (i == 19) begin
            checks += 3;
            if (bus8.out !== 1'b0) begin failures++; $display("FAIL rmid_out got=%b exp=0", bus8.out); end
            if (bus8.soc !== 1'b0) begin failures++; $display("FAIL rmid_soc got=%b exp=0", bus8.soc); end
            if (bus8.len_q !== 8'd6) begin failures++; $display("FAIL rmid_len got=%0d exp=6", bus8.len_q); end
            rst = 1'b0; conv_lat = 0;
         end
         if (i == 23 || i == 24 || i == 29 || i == 30) begin
            checks++;
            if (bus8.out !== (i == 24 || i == 29)) begin
               failures++; $display("FAIL rmid_restart cyc=%0d got=%b exp=%b", i, bus8.out, (i == 24 || i == 29));
            end
         end
         @(negedge clk);
      end
   endtask

   task automatic test_w4();
      int ph;
      int k;
      ph = 0; k = 0;
      bus4.eoc = 1'b1; bus4.numero = '0;
      do_reset();
      for (int i = 0; i < 80; i++) begin
         checks++;
         if ({bus4.out, bus4.soc, bus4.late} !== {m4.out, m4.soc, m4.late} || bus4.len_q !== 4'(m4.len)) begin
            failures++;
            $display("FAIL w4_model cyc=%0d out/soc/late/len got=%b%b%b/%0d exp=%b%b%b/%0d",
                     i, bus4.out, bus4.soc, bus4.late, bus4.len_q, m4.out, m4.soc, m4.late, m4.len);
         end
         if (i == 30 || i == 31 || i == 50 || i == 51) begin
            checks++;
            if (bus4.out !== (i == 30 || i == 50)) begin
               failures++; $display("FAIL w4_out cyc=%0d got=%b exp=%b", i, bus4.out, (i == 30 || i == 50));
            end
         end
         if (i == 36 || i == 56) begin
            checks++;
            if (bus4.late !== 1'b1) begin failures++; $display("FAIL w4_late cyc=%0d got=%b exp=1", i, bus4.late); end
         end
         if (i == 70) begin
            checks += 2;
            if (bus4.soc !== 1'b1) begin failures++; $display("FAIL w4_soc got=%b exp=1", bus4.soc); end
            if (bus4.len_q !== 4'd15) begin failures++; $display("FAIL w4_len got=%0d exp=15", bus4.len_q); end
         end
         // One prompt conversion returning 15, then eoc stays high for good.
         if (ph == 0 && bus4.soc === 1'b1) begin
            bus4.eoc = 1'b0; k = 2; ph = 1;
         end else if (ph == 1) begin
            k--;
            if (k == 0) begin
               bus4.eoc = 1'b1; bus4.numero = 4'd15; ph = 2;
            end
         end
         @(negedge clk);
      end
   endtask

   task automatic test_random();
      conv_rand = 1'b1;
      for (int seg = 0; seg < 3; seg++) begin
         do_reset();
         for (int i = 0; i < 300; i++) begin
            checks++;
            if ({bus8.out, bus8.soc, bus8.late} !== {m8.out, m8.soc, m8.late} || bus8.len_q !== 8'(m8.len)) begin
               failures++;
               $display("FAIL rand_model seg=%0d cyc=%0d out/soc/late/len got=%b%b%b/%0d exp=%b%b%b/%0d",
                        seg, i, bus8.out, bus8.soc, bus8.late, bus8.len_q, m8.out, m8.soc, m8.late, m8.len);
            end
            rst = ($urandom_range(0, 199) == 0);
            @(negedge clk);
         end
      end
      rst = 1'b0;
      conv_rand = 1'b0;
   endtask

   initial begin
      test_reset();
      test_prompt();
      test_zero_numero();
      test_busy_late();
      test_same_edge();
      test_reset_mid();
      test_w4();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/pulse_former_hs.md
PULSE_FORMER_HS -- requirements
Module: pulse_former_hs

Interface
REQ-001 Parameter W, default 8, width of length counter and numero.
REQ-002 Parameter GAP, default 5, cycles out is low between pulses (1..2^W-1).
REQ-003 Parameter LEN0, default 6, pulse length used until the first captured numero (1..2^W-1).
REQ-004 clock  input  1  single clock; all state changes on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 soc  output  1  start-of-conversion request to converter.
REQ-007 eoc  input  1  end-of-conversion; 1 = converter idle/result valid, 0 = busy.
REQ-008 numero  input  W  length of the next pulse, valid while eoc=1 after a conversion.
REQ-009 out  output  1  formed pulse.
REQ-010 late  output  1  one-cycle flag: a pulse started with the handshake still open.
REQ-011 len_q  output  W  pulse length currently in force.

Function
REQ-012 Pulse FSM states GAP, HIGH; handshake FSM states HS_IDLE, HS_REQ, HS_WAIT; both FSMs run concurrently.
REQ-013 GAP: out=0 for exactly GAP cycles, then -> HIGH; counter loaded with GAP on entry.
REQ-014 HIGH: out=1 for exactly len_q cycles (value sampled on the rising edge out goes 1), then -> GAP; period = GAP + len_q.
REQ-015 On the edge entering HIGH, if handshake FSM is HS_IDLE: soc<=1, HS_IDLE -> HS_REQ.
REQ-016 HS_REQ: soc held 1 until eoc sampled 0; on that edge soc<=0, -> HS_WAIT.
REQ-017 HS_WAIT: on first edge eoc sampled 1: len_q<=numero (numero=0 captured as 1), -> HS_IDLE; numero ignored at all other times.
REQ-018 Handshake completion is independent of pulse end; out never stretches or shortens for handshake timing.
REQ-019 Entering HIGH while handshake FSM is HS_REQ or HS_WAIT: no new soc, late=1 for that one cycle, pulse uses old len_q.
REQ-020 Capture on the same edge that enters HIGH: pulse uses old len_q, late=1, new len_q applies to the following pulse.
REQ-021 Counters are W bits, never wrap: load-then-decrement to 1, transition on count==1.
REQ-022 eoc held 1 forever in HS_REQ: soc stays 1, pulses continue with len_q unchanged, late=1 at each pulse start.

Reset
REQ-023 While reset=1 on an edge: out=0, soc=0, late=0, len_q=LEN0, pulse FSM=GAP with counter=GAP, handshake FSM=HS_IDLE.
REQ-024 Reset asserted mid-pulse or mid-handshake aborts both immediately at that edge; no partial capture.
REQ-025 First cycle with reset=0 is cycle 0; out first goes 1 in cycle GAP.

Structure
REQ-026 Shared package holds state enums for both FSMs and GAP/LEN0 defaults.
REQ-027 Handshake FSM (REQ-015..017, 022) is a separate sub-module hs_master, with start/busy/capture ports.
REQ-028 All outputs are registered; no combinational path from eoc or numero to any output.

Verification
REQ-029 Reset, eoc=1 constant with prompt converter (eoc 0 for 2 cycles after soc, numero=3) -> out low cycles 0-4, high 5-10 (6 cycles), then gap 5, next pulse 3 cycles.
REQ-030 Converter returns numero=0 -> len_q=1, following pulse exactly 1 cycle high.
REQ-031 Converter busy 20 cycles (GAP=5, LEN0=6) -> second pulse start has late=1 for one cycle, no second soc, length stays 6.
REQ-032 eoc returns 1 on the exact edge the next pulse starts, numero=9 -> that pulse 6 cycles with late=1, next pulse 9 cycles.
REQ-033 Reset asserted at third cycle of HIGH with soc=1 -> next edge out=0, soc=0, len_q=LEN0; restart timing as REQ-029.
REQ-034 W=4, numero=15 -> pulse exactly 15 cycles, no counter wrap; eoc stuck 1 -> soc held 1, late on every pulse.
